// File: rtl/s2p_align_ctrl_if.sv
// Receive-side bundle of the serial-to-parallel aligner: serial input and
// enable in, aligned byte stream and lock status out.
interface s2p_align_ctrl_if;
  logic       ENABLE;
  logic       DATA_IN;
  logic [7:0] DATA_OUT;
  logic       VALID_OUT;
  logic       K_OUT;
  logic       LOCKED;
  logic [1:0] STATE_OUT;

  modport slave (
    input  ENABLE, DATA_IN,
    output DATA_OUT, VALID_OUT, K_OUT, LOCKED, STATE_OUT
  );

  modport master (
    output ENABLE, DATA_IN,
    input  DATA_OUT, VALID_OUT, K_OUT, LOCKED, STATE_OUT
  );
endinterface

// File: rtl/s2p_align_ctrl.sv
// Comma-based byte aligner: hunts for COMMA at any bit offset, confirms lock over
// LOCK_COUNT aligned commas, then strobes out one aligned byte every 8 clocks.
module s2p_align_ctrl #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  s2p_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COUNT  = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);

  state_t     state, state_n;
  logic [7:0] sr, nxt;
  logic [7:0] data_q, data_n;
  logic [2:0] bit_cnt, bit_n;
  logic [3:0] com_cnt, com_n, com_inc;
  logic       valid_q, valid_n;
  logic       k_q, k_n;
  logic       locked_q;
  logic       is_comma, boundary;

  assign nxt      = {sr[6:0], bus.DATA_IN};
  assign is_comma = (nxt == COMMA);
  assign boundary = (bit_cnt == 3'd7);
  assign com_inc  = com_cnt + 4'd1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      k_q      <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_n;
      sr       <= nxt;
      bit_cnt  <= bit_n;
      com_cnt  <= com_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      k_q      <= k_n;
      locked_q <= (state_n == ACTIVE);
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt + 3'd1;
    com_n   = com_cnt;
    data_n  = data_q;
    valid_n = 1'b0;
    k_n     = k_q;
    if (!bus.ENABLE) begin
      state_n = IDLE;
      bit_n   = '0;
      com_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = SEARCH;
          bit_n   = '0;
          com_n   = '0;
        end
        SEARCH: begin
          // Sliding-window hunt; a hit fixes the byte phase at this edge.
          bit_n = '0;
          if (is_comma) begin
            com_n   = 4'd1;
            state_n = (LOCK_TGT == 4'd1) ? ACTIVE : COUNT;
          end
        end
        COUNT: begin
          if (boundary) begin
            if (is_comma) begin
              com_n = com_inc;
              if (com_inc == LOCK_TGT) state_n = ACTIVE;
            end else begin
              com_n   = '0;
              state_n = SEARCH;
            end
          end
        end
        ACTIVE: begin
          if (boundary) begin
            data_n  = nxt;
            valid_n = 1'b1;
            k_n     = is_comma;
          end
        end
      endcase
    end
  end

  assign bus.DATA_OUT  = data_q;
  assign bus.VALID_OUT = valid_q;
  assign bus.K_OUT     = k_q;
  assign bus.LOCKED    = locked_q;
  assign bus.STATE_OUT = state;

endmodule

// File: tb/tb_s2p_align_ctrl.sv
// Scoreboard bench for s2p_align_ctrl: two instances (LOCK_COUNT 2 and 1) share a
// serial stream; a timestamp-based reference model predicts state and output bytes.
module tb_s2p_align_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  logic en, din;

  always #5 CLK = ~CLK;

  s2p_align_ctrl_if bus_a ();
  s2p_align_ctrl_if bus_b ();

  assign bus_a.ENABLE  = en;
  assign bus_a.DATA_IN = din;
  assign bus_b.ENABLE  = en;
  assign bus_b.DATA_IN = din;

  s2p_align_ctrl #(.COMMA(8'hBC), .LOCK_COUNT(2)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a)
  );

  s2p_align_ctrl #(.COMMA(8'hBC), .LOCK_COUNT(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       k;
  } exp_t;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model: 0 idle, 1 hunting, 2 confirming, 3 locked. Byte boundaries are edges
  // whose index is a multiple of 8 after the comma that fixed the phase.
  int mode[2];
  int cnt[2];
  int anchor[2];
  int lockn[2] = '{2, 1};
  logic [7:0] win;
  int t = 0;
  int pulses_a = 0;
  int pulses_b = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i]   = 0;
      cnt[i]    = 0;
      anchor[i] = 0;
    end
    win = 8'h00;
    q_a.delete();
    q_b.delete();
  endfunction

  function automatic void model_step(input logic e, input logic b);
    logic [7:0] w;
    exp_t x;
    w = {win[6:0], b};
    for (int i = 0; i < 2; i++) begin
      if (!e) begin
        mode[i] = 0;
        cnt[i]  = 0;
      end else begin
        case (mode[i])
          0: mode[i] = 1;
          1: if (w == 8'hBC) begin
               anchor[i] = t;
               cnt[i]    = 1;
               mode[i]   = (cnt[i] == lockn[i]) ? 3 : 2;
             end
          2: if ((t - anchor[i]) % 8 == 0) begin
               if (w == 8'hBC) begin
                 cnt[i]++;
                 if (cnt[i] == lockn[i]) mode[i] = 3;
               end else begin
                 cnt[i]  = 0;
                 mode[i] = 1;
               end
             end
          default: if ((t - anchor[i]) % 8 == 0) begin
               x.d = w;
               x.k = (w == 8'hBC);
               if (i == 0) q_a.push_back(x);
               else        q_b.push_back(x);
             end
        endcase
      end
    end
    win = w;
    t++;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge CLK);
    din = b;
    model_step(en, b);
    @(posedge CLK);
    #1;
    check("a_state",  bus_a.STATE_OUT, mode[0]);
    check("a_locked", bus_a.LOCKED,    mode[0] == 3);
    check("b_state",  bus_b.STATE_OUT, mode[1]);
    check("b_locked", bus_b.LOCKED,    mode[1] == 3);
    if (bus_a.VALID_OUT) pulses_a++;
    if (bus_b.VALID_OUT) pulses_b++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic check_cleared();
    check("a_rst_state", bus_a.STATE_OUT, 0);
    check("a_rst_lock",  bus_a.LOCKED,    0);
    check("a_rst_valid", bus_a.VALID_OUT, 0);
    check("a_rst_data",  bus_a.DATA_OUT,  0);
    check("a_rst_k",     bus_a.K_OUT,     0);
    check("b_rst_state", bus_b.STATE_OUT, 0);
    check("b_rst_lock",  bus_b.LOCKED,    0);
    check("b_rst_valid", bus_b.VALID_OUT, 0);
    check("b_rst_data",  bus_b.DATA_OUT,  0);
    check("b_rst_k",     bus_b.K_OUT,     0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    #1;
    check_cleared();
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1;
      check_cleared();
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      check("a_no_back_to_back", prev_a && bus_a.VALID_OUT, 0);
      if (bus_a.VALID_OUT) begin
        check("a_strobe_expected", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          e = q_a.pop_front();
          check("a_data", bus_a.DATA_OUT, e.d);
          check("a_k",    bus_a.K_OUT,    e.k);
        end
      end
    end
    prev_a = bus_a.VALID_OUT;
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      check("b_no_back_to_back", prev_b && bus_b.VALID_OUT, 0);
      if (bus_b.VALID_OUT) begin
        check("b_strobe_expected", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
          e = q_b.pop_front();
          check("b_data", bus_b.DATA_OUT, e.d);
          check("b_k",    bus_b.K_OUT,    e.k);
        end
      end
    end
    prev_b = bus_b.VALID_OUT;
  end

  initial begin
    int p0;
    int r;
    RESET = 1'b1;
    en    = 1'b0;
    din   = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    do_reset(4);
    en = 1'b1;

    // Junk prefix then two commas and three data bytes.
    p0 = pulses_a;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'hBC);
    send_byte(8'h3D); send_byte(8'h0C); send_byte(8'h55);
    check("a_pulses_lock2", pulses_a - p0, 3);

    // Reset while locked, then a broken lock attempt followed by a good one.
    do_reset(4);
    en = 1'b1;
    send_byte(8'hBC); send_byte(8'h3D); send_byte(8'hBC); send_byte(8'hBC);
    p0 = pulses_a;
    send_byte(8'hAA);
    check("a_first_after_relock", pulses_a - p0, 1);

    // K flag, then a comma straddling the current byte boundary.
    send_byte(8'hBC); send_byte(8'hF7);
    send_byte(8'h0B); send_byte(8'hC0); send_byte(8'h5A);

    // Single-comma lock on instance b, then drop ENABLE.
    do_reset(4);
    en = 1'b1;
    send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC); send_byte(8'h12); send_byte(8'h34);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    en = 1'b0;
    p0 = pulses_b;
    for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
    check("b_no_pulse_disabled", pulses_b - p0, 0);
    en = 1'b1;

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset($urandom_range(1, 4));
        en = 1'b1;
      end else if (r < 7) begin
        en = ~en;
        send_bit(1'($urandom_range(0, 1)));
      end else if (r < 20) begin
        for (int j = 0; j < int'($urandom_range(1, 7)); j++) send_bit(1'($urandom_range(0, 1)));
      end else if (r < 55) begin
        send_byte(8'hBC);
      end else if (r < 62) begin
        send_byte(8'hF7);
      end else begin
        send_byte(8'($urandom_range(0, 255)));
      end
    end

    @(negedge CLK);
    #1;
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s2p_align_ctrl.md
Name: s2p_align_ctrl

Overview:
Controller that sequences the serial-to-parallel datapath. It watches the 1-bit serial stream, finds the comma symbol (COMMA, 0xBC) at any bit offset and fixes the byte boundary there. It declares lock after LOCK_COUNT back-to-back aligned commas, then delivers aligned parallel bytes with a valid strobe and a K-symbol flag. It sits between the serial input pin and the byte-wide receive logic.

Parameters:
COMMA, 8'hBC, alignment/control symbol, compared MSB-first
LOCK_COUNT, 2, consecutive aligned commas needed to reach ACTIVE (legal range 1..15)

Ports:
CLK  input  1  clock; one serial bit per rising edge
RESET  input  1  asynchronous, active-high reset
ENABLE  input  1  1 = run the aligner; 0 = return to IDLE
DATA_IN  input  1  serial data, MSB of each byte first
DATA_OUT  output  8  aligned byte
VALID_OUT  output  1  one-cycle strobe; DATA_OUT holds a new byte
K_OUT  output  1  qualifies VALID_OUT; 1 when DATA_OUT==COMMA
LOCKED  output  1  1 while in ACTIVE
STATE_OUT  output  2  IDLE=0, SEARCH=1, COUNT=2, ACTIVE=3

Behaviour:
- RESET=1, at any time including mid-byte or mid-lock:
  - state goes to IDLE immediately.
  - shift register, bit counter (3b) and comma counter (4b) clear to 0.
  - DATA_OUT=0, VALID_OUT=0, K_OUT=0, LOCKED=0, STATE_OUT=0.
- Every rising edge (RESET low): sr <= {sr[6:0], DATA_IN}. Define nxt = {sr[6:0], DATA_IN}.
- ENABLE=0 at an edge, from any state: go to IDLE and clear both counters. VALID_OUT=0 and LOCKED=0 from that edge.
- IDLE: ENABLE=1 -> SEARCH on the next edge. The shift register keeps shifting in IDLE.
- SEARCH: compare nxt against COMMA on every edge (sliding window).
  - On a match: bit_cnt <= 0, com_cnt <= 1.
  - Go to COUNT, or straight to ACTIVE if LOCK_COUNT==1.
  - No output strobe in SEARCH.
- COUNT:
  - bit_cnt increments each edge.
  - At the byte-boundary edge (bit_cnt==7), if nxt==COMMA: com_cnt+1. If this equals LOCK_COUNT, go to ACTIVE; otherwise stay in COUNT.
  - At the boundary, if nxt!=COMMA: go to SEARCH, com_cnt <= 0.
  - Commas consumed during lock acquisition are never output.
- ACTIVE:
  - bit_cnt wraps 7->0 freely.
  - At each boundary edge: DATA_OUT <= nxt, VALID_OUT <= 1, K_OUT <= (nxt==COMMA).
  - All other edges: VALID_OUT <= 0. K_OUT and DATA_OUT hold their last values.
- Latency and throughput:
  - The last bit of a byte is sampled at edge k. VALID_OUT is high from edge k to edge k+1, and DATA_OUT is stable until the next boundary.
  - Exactly one strobe per 8 clocks in ACTIVE; no back-pressure.
- ACTIVE ignores commas at other bit offsets: no realignment and no lock loss. Only RESET or ENABLE=0 leaves ACTIVE.
- LOCKED is registered: it goes high at the edge that enters ACTIVE and low at the edge that leaves it.
- Counter widths: bit_cnt 3 bits, wraps modulo 8. com_cnt 4 bits, never exceeds LOCK_COUNT.

Test Plan:
1. Assert RESET for 4 cycles mid-stream, including once while in ACTIVE -> all outputs 0 and STATE_OUT=0 while RESET is high. After release with ENABLE=1: STATE_OUT=1 after one edge.
2. LOCK_COUNT=2, ENABLE=1, stream 3 junk bits 101, then 0xBC, 0xBC, 0x3D, 0x0C, 0x55 MSB-first ->
   - SEARCH->COUNT on the last bit of the first 0xBC; ACTIVE on the last bit of the second.
   - VALID_OUT pulses 3 times with DATA_OUT 0x3D, 0x0C, 0x55, K_OUT=0 each time.
3. Stream 0xBC, 0x3D, 0xBC, 0xBC, 0xAA ->
   - 0x3D in COUNT returns to SEARCH with com_cnt cleared.
   - Lock is reached on the 4th byte; the first output is 0xAA.
4. In ACTIVE, send 0xBC -> VALID_OUT=1, DATA_OUT=0xBC, K_OUT=1. Then send 0xF7 -> K_OUT=0. VALID_OUT is never high two consecutive cycles.
5. In ACTIVE, shift 0xBC straddling a byte boundary (4-bit offset) -> no realignment; LOCKED stays 1; bytes 0x?B and 0xC? are output per the existing alignment.
6. LOCK_COUNT=1: a single 0xBC goes straight to ACTIVE. Then drop ENABLE -> IDLE on the next edge, LOCKED=0, no further VALID_OUT pulses.
